// File: rtl/multi_oneshot_pkg.sv
// multi_oneshot_pkg: shared state type and config-field slicing helper for the one-shot generator
package multi_oneshot_pkg;
  typedef enum logic [1:0] {IDLE, DELAY, PULSE} state_t;
  function automatic int fld_lsb(input int idx, input int w);
    return idx * w;
  endfunction
endpackage

// File: rtl/multi_oneshot_gen_if.sv
// multi_oneshot_gen_if: trigger/config inputs and pulse/status outputs of the one-shot generator
interface multi_oneshot_gen_if #(parameter int CH = 4, parameter int CNT_W = 8);
  logic [CH-1:0] TRIG;
  logic [CH*CNT_W-1:0] WIDTH_CFG;
  logic [CH*CNT_W-1:0] DELAY_CFG;
  logic [CH-1:0] OUT;
  logic [CH-1:0] OUTN;
  logic [CH-1:0] BUSY;
  logic [CH-1:0] DONE;
  modport master(output TRIG, WIDTH_CFG, DELAY_CFG, input OUT, OUTN, BUSY, DONE);
  modport slave(input TRIG, WIDTH_CFG, DELAY_CFG, output OUT, OUTN, BUSY, DONE);
endinterface

// File: rtl/multi_oneshot_chan.sv
// multi_oneshot_chan: one retriggerable delayed one-shot channel.
// MULTI_ONESHOT_POWERON_PULSE_EN: fire a DEFAULT_WIDTH pulse on the first edge after reset release.
module multi_oneshot_chan
  import multi_oneshot_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int RETRIG = 1,
  parameter int DEFAULT_WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             trig,
  input  logic [CNT_W-1:0] width_cfg,
  input  logic [CNT_W-1:0] delay_cfg,
  output logic             out,
  output logic             outn,
  output logic             busy,
  output logic             done
);
`ifdef MULTI_ONESHOT_POWERON_PULSE_EN
  localparam bit PO_EN = 1'b1;
`else
  localparam bit PO_EN = 1'b0;
`endif
  localparam bit RT = RETRIG != 0;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, w_q, w_n;
  logic out_n, done_n, trig_q, po_q, take;
  assign take = trig & ~trig_q & (state == IDLE || RT);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    w_n = w_q;
    out_n = out;
    done_n = 1'b0;
    if (po_q) begin
      state_n = PULSE;
      cnt_n = CNT_W'(DEFAULT_WIDTH - 1);
      w_n = CNT_W'(DEFAULT_WIDTH);
      out_n = 1'b1;
    end else if (take && state == PULSE) begin
      // extension keeps OUT high; zero width ends the pulse here
      w_n = width_cfg;
      if (width_cfg == '0) begin
        state_n = IDLE;
        out_n = 1'b0;
        done_n = 1'b1;
      end else cnt_n = width_cfg - 1'b1;
    end else if (take) begin
      w_n = width_cfg;
      if (width_cfg == '0) state_n = IDLE;
      else if (delay_cfg == '0) begin
        state_n = PULSE;
        cnt_n = width_cfg - 1'b1;
        out_n = 1'b1;
      end else begin
        state_n = DELAY;
        cnt_n = delay_cfg - 1'b1;
      end
    end else if (state == DELAY) begin
      state_n = cnt == '0 ? PULSE : DELAY;
      cnt_n = cnt == '0 ? w_q - 1'b1 : cnt - 1'b1;
      out_n = cnt == '0;
    end else if (state == PULSE) begin
      state_n = cnt == '0 ? IDLE : PULSE;
      cnt_n = cnt == '0 ? cnt : cnt - 1'b1;
      out_n = cnt != '0;
      done_n = cnt == '0;
    end
  end
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= IDLE;
      cnt <= '0;
      w_q <= '0;
      out <= 1'b0;
      outn <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      trig_q <= 1'b1;
      po_q <= PO_EN;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      w_q <= w_n;
      out <= out_n;
      outn <= ~out_n;
      busy <= state_n != IDLE;
      done <= done_n;
      trig_q <= trig;
      po_q <= 1'b0;
    end
  end
endmodule

// File: rtl/multi_oneshot_gen.sv
// multi_oneshot_gen: CH independent delayed one-shot channels behind a packed bus interface
module multi_oneshot_gen
  import multi_oneshot_pkg::*;
#(
  parameter int CH = 4,
  parameter int CNT_W = 8,
  parameter int RETRIG = 1,
  parameter int DEFAULT_WIDTH = 8
) (
  input logic CLK,
  input logic RSTN,
  multi_oneshot_gen_if.slave bus
);
  logic [CH-1:0] out_v, outn_v, busy_v, done_v;
  for (genvar i = 0; i < CH; i++) begin : g_ch
    multi_oneshot_chan #(
      .CNT_W(CNT_W),
      .RETRIG(RETRIG),
      .DEFAULT_WIDTH(DEFAULT_WIDTH)
    ) u_chan (
      .CLK(CLK),
      .RSTN(RSTN),
      .trig(bus.TRIG[i]),
      .width_cfg(bus.WIDTH_CFG[fld_lsb(i, CNT_W) +: CNT_W]),
      .delay_cfg(bus.DELAY_CFG[fld_lsb(i, CNT_W) +: CNT_W]),
      .out(out_v[i]),
      .outn(outn_v[i]),
      .busy(busy_v[i]),
      .done(done_v[i])
    );
  end
  assign bus.OUT = out_v;
  assign bus.OUTN = outn_v;
  assign bus.BUSY = busy_v;
  assign bus.DONE = done_v;
endmodule

// File: tb/tb_multi_oneshot_gen.sv
// tb_multi_oneshot_gen: directed checks of a retriggerable (a) and a non-retriggerable (b) generator
module tb_multi_oneshot_gen;
  logic CLK, RSTN;
  logic [3:0] trig_a, trig_b;
  logic [31:0] wcfg, dcfg;
  logic [10:0] pa, pb, ea_out, ea_done, eb_out, eb_done;
  int checks = 0, errors = 0;
  multi_oneshot_gen_if #(.CH(4), .CNT_W(8)) ifa ();
  multi_oneshot_gen_if #(.CH(4), .CNT_W(8)) ifb ();
  assign ifa.TRIG = trig_a;
  assign ifb.TRIG = trig_b;
  assign ifa.WIDTH_CFG = wcfg;
  assign ifb.WIDTH_CFG = wcfg;
  assign ifa.DELAY_CFG = dcfg;
  assign ifb.DELAY_CFG = dcfg;
  multi_oneshot_gen #(.CH(4), .CNT_W(8), .RETRIG(1), .DEFAULT_WIDTH(8)) dut_a (
    .CLK(CLK), .RSTN(RSTN), .bus(ifa)
  );
  multi_oneshot_gen #(.CH(4), .CNT_W(8), .RETRIG(0), .DEFAULT_WIDTH(8)) dut_b (
    .CLK(CLK), .RSTN(RSTN), .bus(ifb)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  initial begin
    RSTN = 1'b0;
    trig_a = 4'hF;
    trig_b = 4'hF;
    wcfg = 32'h00_04_03_05;
    dcfg = 32'h00_00_04_00;
    pa = 11'h045;
    pb = 11'h025;
    ea_out = 11'h3FF;
    ea_done = 11'h400;
    eb_out = 11'h1EF;
    eb_done = 11'h210;
    repeat (3) tick();
    chk("rst_out", ifa.OUT, 0);
    chk("rst_outn", ifa.OUTN, 4'hF);
    chk("rst_busy", ifa.BUSY, 0);
    chk("rst_done", ifa.DONE, 0);
    chk("rst_outn_b", ifb.OUTN, 4'hF);
    RSTN = 1'b1;
`ifdef MULTI_ONESHOT_POWERON_PULSE_EN
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("po_out", ifa.OUT, 4'hF);
      chk("po_outn", ifa.OUTN, 4'h0);
    end
    tick();
    chk("po_done", ifa.DONE, 4'hF);
    chk("po_fall", ifa.OUT, 4'h0);
`else
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("hold_out", ifa.OUT, 0);
      chk("hold_outn", ifa.OUTN, 4'hF);
      chk("hold_busy", ifb.BUSY, 0);
    end
`endif
    trig_a = 4'h0;
    trig_b = 4'h0;
    repeat (2) tick();
    trig_a[0] = 1'b1;
    trig_b[0] = 1'b1;
    for (int j = 0; j < 7; j++) begin
      tick();
      trig_a[0] = 1'b0;
      trig_b[0] = 1'b0;
      chk("basic_out_a", ifa.OUT[0], j < 5);
      chk("basic_out_b", ifb.OUT[0], j < 5);
      chk("basic_outn", ifa.OUTN[0], j >= 5);
      chk("basic_done", ifa.DONE[0], j == 5);
    end
    trig_a[1] = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick();
      trig_a[1] = 1'b0;
      wcfg[15:8] = 8'd9;
      chk("dly_out", ifa.OUT[1], j >= 4 && j <= 6);
      chk("dly_busy", ifa.BUSY[1], j <= 6);
      chk("dly_done", ifa.DONE[1], j == 7);
    end
    for (int j = 0; j < 11; j++) begin
      trig_a[2] = pa[j];
      trig_b[2] = pb[j];
      tick();
      chk("rt1_out", ifa.OUT[2], ea_out[j]);
      chk("rt1_done", ifa.DONE[2], ea_done[j]);
      chk("rt0_out", ifb.OUT[2], eb_out[j]);
      chk("rt0_done", ifb.DONE[2], eb_done[j]);
    end
    trig_a = 4'h0;
    trig_b = 4'h0;
    tick();
    trig_a[3] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      trig_a[3] = 1'b0;
      chk("w0_out", ifa.OUT[3], 0);
      chk("w0_busy", ifa.BUSY[3], 0);
      chk("w0_done", ifa.DONE[3], 0);
    end
    wcfg[31:24] = 8'd6;
    trig_a[3] = 1'b1;
    repeat (2) tick();
    trig_a[3] = 1'b0;
    chk("mid_out", ifa.OUT[3], 1);
    #2;
    RSTN = 1'b0;
    #1;
    chk("mid_rst_out", ifa.OUT, 0);
    chk("mid_rst_outn", ifa.OUTN, 4'hF);
    chk("mid_rst_busy", ifa.BUSY, 0);
    repeat (2) begin
      tick();
      chk("mid_rst_done", ifa.DONE, 0);
    end
    RSTN = 1'b1;
    tick();
`ifdef MULTI_ONESHOT_POWERON_PULSE_EN
    chk("post_rst_out", ifa.OUT, 4'hF);
`else
    chk("post_rst_out", ifa.OUT, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
